cp2_cpu_port: RTL
=================

// Module: cp2_cpu_port
// PURPOSE
// - CPU-side initiator for the CP2 coprocessor channel; the cp2 block is the responder on the same wires.
// - Accepts one coprocessor op per request from the pipeline (exec / move-to / move-from).
// - Sequences IR delivery, busy waits, the as/ts/fs strobes and the tds/fds data acknowledges.
// - Returns read data or a CP2 exception to the pipeline; holds stall high meanwhile.
// PARAMETERS
// - DW, 32: word width, matches WORDDATABUS.
// - ECW, 5: exception-code width, matches CP2EXECCODEBUS.
// - TMO, 255: max cycles spent in any wait state before abort; 0 disables the timeout.
// PORTS
// - clk         in   1    system clock
// - rst         in   1    synchronous reset, active high
// - req_valid   in   1    pipeline op request, sampled only in IDLE
// - req_kind    in   2    00 exec(as), 01 move-to(ts), 10 move-from(fs), 11 illegal
// - req_ir      in   DW   coprocessor instruction word
// - req_wdata   in   DW   data for move-to
// - stall       out  1    high from the accepting cycle until the cycle rsp_valid/exc_valid/tmo_valid pulses
// - rsp_valid   out  1    1-cycle pulse, op completed without error
// - rsp_rdata   out  DW   move-from result, held until next accept
// - exc_valid   out  1    1-cycle pulse, CP2 raised an exception for this op
// - exc_code    out  ECW  latched cp2_exccode_0, held until next accept
// - tmo_valid   out  1    1-cycle pulse, wait-state timeout abort
// - cp2_irenable_0 out 1  IR valid to CP2
// - cp2_ir_0    out  DW   IR to CP2
// - cp2_as_0 / cp2_ts_0 / cp2_fs_0  out 1 each  exec / move-to / move-from strobe
// - cp2_tdata_0 out  DW   move-to data
// - cp2_abusy_0 / cp2_tbusy_0 / cp2_fbusy_0  in 1 each  CP2 busy per channel
// - cp2_tds_0   in   1    CP2 took tdata
// - cp2_fds_0   in   1    cp2_fdata_0 valid
// - cp2_fdata_0 in   DW   move-from data
// - cp2_excs_0  in   1    exception status strobe
// - cp2_exc_0   in   1    exception flag (valid with excs)
// - cp2_exccode_0 in ECW exception cause
// BEHAVIOUR
// - Reset: all outputs 0, rsp_rdata/exc_code/cp2_ir_0/cp2_tdata_0 0, state IDLE, timer 0. Reset mid-op drops the op; no response pulse.
// - FSM: IDLE -> ISSUE -> WAITB -> STRB -> WACK -> DONE -> IDLE; any wait -> EXC or TMO -> IDLE.
// - IDLE: stall=0. req_valid=1 registers ir/kind/wdata, stall=1 next cycle. kind 11 -> EXC with code all-ones, no CP2 traffic.
// - ISSUE (1 cycle): cp2_irenable_0=1, cp2_ir_0=ir. irenable is high only in ISSUE.
// - WAITB: wait until the kind's busy (abusy/tbusy/fbusy) is 0 at a clock edge.
// - STRB (1 cycle): the matching strobe=1; move-to also drives cp2_tdata_0 from STRB until WACK exits.
// - WACK exec: complete in the cycle after STRB unless excs. Move-to: wait tds. Move-from: wait fds, capture fdata.
// - DONE: rsp_valid=1 for 1 cycle; stall drops in the same cycle. A new req is accepted the cycle after.
// - Exceptions: cp2_excs_0 & cp2_exc_0 in WAITB/STRB/WACK -> latch exccode, go to EXC; exc_valid=1 for 1 cycle; no rsp_valid.
// - excs with exc=0 is ignored.
// - Priority in one cycle: exception > ack (tds/fds) > timeout.
// - Timer: cleared on entry to WAITB and to WACK, +1 per cycle spent there.
// - Timeout: timer==TMO with TMO!=0 -> TMO state; tmo_valid=1 for 1 cycle; exc_code unchanged.
// - Min latency, exec, busy low: accept at T, ISSUE T+1, WAITB T+2, STRB T+3, WACK T+4, rsp_valid T+5.
// - Strobes are mutually exclusive and 1 cycle wide. They never assert while the matching busy was high at the last edge.
// STRUCTURE
// - Shared package (cp2.vh): req_kind encodings, FSM state encodings, CP2 exccode widths.
// - One sub-module, cp2_wait_timer: counter with clear, enable and TMO compare; everything else is flat.
// TESTING
// - Exec, abusy=0, no exc: req at T -> as pulse at T+3, rsp_valid at T+5, stall high T+1..T+4.
// - Move-to wdata=0xDEADBEEF, tbusy high 4 cycles, tds 2 cycles after ts -> tdata=0xDEADBEEF held through tds, then rsp_valid.
// - Move-from, fds with fdata=0x12345678 -> rsp_rdata=0x12345678, rsp_valid 1 cycle later.
// - Exec with excs=1, exc=1, code=5'h0C in WACK -> exc_valid pulse, exc_code=0x0C, no rsp_valid.
// - Same-cycle tds and exception in WACK -> exception path wins.
// - TMO=8, fbusy stuck high -> tmo_valid after 8 WAITB cycles, fs never asserted.
// - Reset asserted mid-WACK -> all outputs 0 next cycle, FSM in IDLE.
// - kind=11 -> exc_valid, code 5'h1F, irenable never asserted.

Source files
------------

// File: rtl/cp2_pkg.sv
// Shared definitions for the CPU-side CP2 channel port: op kinds, FSM states, default widths.
package cp2_pkg;

    localparam int unsigned CP2_DW  = 32;
    localparam int unsigned CP2_ECW = 5;
    localparam int unsigned CP2_TMO = 255;

    typedef enum logic [1:0] {
        KIND_EXEC  = 2'b00,
        KIND_MTO   = 2'b01,
        KIND_MFROM = 2'b10,
        KIND_ILL   = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAITB = 3'd2,
        ST_STRB  = 3'd3,
        ST_WACK  = 3'd4,
        ST_DONE  = 3'd5,
        ST_EXC   = 3'd6,
        ST_TMO   = 3'd7
    } state_e;

    // Busy line that gates the strobe for a given op kind.
    function automatic logic kind_busy(input kind_e k, input logic abusy,
                                       input logic tbusy, input logic fbusy);
        case (k)
            KIND_EXEC:  kind_busy = abusy;
            KIND_MTO:   kind_busy = tbusy;
            KIND_MFROM: kind_busy = fbusy;
            default:    kind_busy = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cp2_wait_timer.sv
// Wait-state cycle counter with clear, enable and timeout compare (TMO=0 never hits).
module cp2_wait_timer #(
    parameter int unsigned TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit_c
);

    localparam int unsigned TW = (TMO == 0) ? 1 : $clog2(TMO + 1);

    logic [TW-1:0] count;

    // Saturates at TMO so a long wait cannot wrap back below the limit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != TW'(TMO))) begin
            count <= count + TW'(1);
        end
    end

    assign hit_c = (TMO != 0) && (count == TW'(TMO));

endmodule

// File: rtl/cp2_cpu_port.sv
// CPU-side initiator for the CP2 coprocessor channel: issues IR, waits on busy,
// strobes exec/move-to/move-from, collects the data ack and reports result or exception.
module cp2_cpu_port
    import cp2_pkg::*;
#(
    parameter int unsigned DW  = CP2_DW,
    parameter int unsigned ECW = CP2_ECW,
    parameter int unsigned TMO = CP2_TMO
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    input  logic [1:0]     req_kind,
    input  logic [DW-1:0]  req_ir,
    input  logic [DW-1:0]  req_wdata,
    output logic           stall,
    output logic           rsp_valid,
    output logic [DW-1:0]  rsp_rdata,
    output logic           exc_valid,
    output logic [ECW-1:0] exc_code,
    output logic           tmo_valid,
    output logic           cp2_irenable_0,
    output logic [DW-1:0]  cp2_ir_0,
    output logic           cp2_as_0,
    output logic           cp2_ts_0,
    output logic           cp2_fs_0,
    output logic [DW-1:0]  cp2_tdata_0,
    input  logic           cp2_abusy_0,
    input  logic           cp2_tbusy_0,
    input  logic           cp2_fbusy_0,
    input  logic           cp2_tds_0,
    input  logic           cp2_fds_0,
    input  logic [DW-1:0]  cp2_fdata_0,
    input  logic           cp2_excs_0,
    input  logic           cp2_exc_0,
    input  logic [ECW-1:0] cp2_exccode_0
);

    state_e          state;
    kind_e           kind;
    logic [DW-1:0]   wdata;
    logic            busy_sel;
    logic            exc_hit;
    logic            ack_hit;
    logic            tmo_hit;

    always_comb begin
        busy_sel = kind_busy(kind, cp2_abusy_0, cp2_tbusy_0, cp2_fbusy_0);
        exc_hit  = cp2_excs_0 & cp2_exc_0;
        ack_hit  = (kind == KIND_EXEC) ||
                   ((kind == KIND_MTO)   && cp2_tds_0) ||
                   ((kind == KIND_MFROM) && cp2_fds_0);
    end

    // Timer restarts on every entry to a wait state (entries come only from ISSUE and STRB).
    cp2_wait_timer #(.TMO(TMO)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state == ST_ISSUE) || (state == ST_STRB)),
        .en    ((state == ST_WAITB) || (state == ST_WACK)),
        .hit_c (tmo_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            kind           <= KIND_EXEC;
            wdata          <= '0;
            stall          <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            exc_valid      <= 1'b0;
            exc_code       <= '0;
            tmo_valid      <= 1'b0;
            cp2_irenable_0 <= 1'b0;
            cp2_ir_0       <= '0;
            cp2_as_0       <= 1'b0;
            cp2_ts_0       <= 1'b0;
            cp2_fs_0       <= 1'b0;
            cp2_tdata_0    <= '0;
        end else begin
            rsp_valid      <= 1'b0;
            exc_valid      <= 1'b0;
            tmo_valid      <= 1'b0;
            cp2_irenable_0 <= 1'b0;
            cp2_as_0       <= 1'b0;
            cp2_ts_0       <= 1'b0;
            cp2_fs_0       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        kind      <= kind_e'(req_kind);
                        wdata     <= req_wdata;
                        rsp_rdata <= '0;
                        if (req_kind == KIND_ILL) begin
                            state     <= ST_EXC;
                            exc_valid <= 1'b1;
                            exc_code  <= '1;
                        end else begin
                            state          <= ST_ISSUE;
                            stall          <= 1'b1;
                            exc_code       <= '0;
                            cp2_irenable_0 <= 1'b1;
                            cp2_ir_0       <= req_ir;
                        end
                    end
                end
                ST_ISSUE: begin
                    state    <= ST_WAITB;
                    cp2_ir_0 <= '0;
                end
                ST_WAITB: begin
                    if (exc_hit) begin
                        state     <= ST_EXC;
                        stall     <= 1'b0;
                        exc_valid <= 1'b1;
                        exc_code  <= cp2_exccode_0;
                    end else if (!busy_sel) begin
                        state    <= ST_STRB;
                        cp2_as_0 <= (kind == KIND_EXEC);
                        cp2_ts_0 <= (kind == KIND_MTO);
                        cp2_fs_0 <= (kind == KIND_MFROM);
                        if (kind == KIND_MTO) begin
                            cp2_tdata_0 <= wdata;
                        end
                    end else if (tmo_hit) begin
                        state     <= ST_TMO;
                        stall     <= 1'b0;
                        tmo_valid <= 1'b1;
                    end
                end
                ST_STRB: begin
                    if (exc_hit) begin
                        state       <= ST_EXC;
                        stall       <= 1'b0;
                        exc_valid   <= 1'b1;
                        exc_code    <= cp2_exccode_0;
                        cp2_tdata_0 <= '0;
                    end else begin
                        state <= ST_WACK;
                    end
                end
                // Exception outranks the data ack, which outranks the timeout.
                ST_WACK: begin
                    if (exc_hit) begin
                        state       <= ST_EXC;
                        stall       <= 1'b0;
                        exc_valid   <= 1'b1;
                        exc_code    <= cp2_exccode_0;
                        cp2_tdata_0 <= '0;
                    end else if (ack_hit) begin
                        state       <= ST_DONE;
                        stall       <= 1'b0;
                        rsp_valid   <= 1'b1;
                        cp2_tdata_0 <= '0;
                        if (kind == KIND_MFROM) begin
                            rsp_rdata <= cp2_fdata_0;
                        end
                    end else if (tmo_hit) begin
                        state       <= ST_TMO;
                        stall       <= 1'b0;
                        tmo_valid   <= 1'b1;
                        cp2_tdata_0 <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
